// File: rtl/bus_pkg.sv
// Shared definitions for the single-cycle register bus.
// Provides the op encoding, the default bus widths and the state type of the
// bus_master FSM.
package bus_pkg;

    // Bus op encoding. Requests and bus commands use the same encoding.
    localparam logic BUS_OP_READ  = 1'b0;
    localparam logic BUS_OP_WRITE = 1'b1;

    // Default widths of the register bus.
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RD_WAIT,
        RSP
    } state_e;

endpackage

// File: rtl/bus_master_if.sv
// Request, response and register-bus signals around bus_master.
//   master : the bus_master view (accepts requests, drives responses and bus)
//   slave  : the register slave view (receives commands, returns read data)
//   agent  : the CPU/test-side view (issues requests, consumes responses)
interface bus_master_if #(
    parameter int ADDR_W = bus_pkg::DEF_ADDR_W,
    parameter int DATA_W = bus_pkg::DEF_DATA_W
);
    // Request port
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    // Response port
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_op;
    logic [DATA_W-1:0] rsp_rdata;

    // Register bus
    logic              bus_cmd_valid;
    logic              bus_op;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready, bus_rd_data,
        output req_ready, rsp_valid, rsp_op, rsp_rdata,
        output bus_cmd_valid, bus_op, bus_addr, bus_wr_data
    );

    modport slave (
        input  bus_cmd_valid, bus_op, bus_addr, bus_wr_data,
        output bus_rd_data
    );

    modport agent (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_op, rsp_rdata
    );

endinterface

// File: rtl/bus_master.sv
// Initiator for the single-cycle register bus.
// Accepts one request at a time, issues exactly one bus command per request,
// samples read data RD_LATENCY cycles after the command and returns a
// response. All outputs come from registers or from the state register.
// Ports:
//   clk, rst_n : clock (posedge) and asynchronous active-low reset
//   bif        : request/response/bus signals (bus_master_if.master)
//   busy       : high whenever the FSM is not IDLE
//   txn_count  : number of completed responses, wraps at 16 bits
module bus_master
    import bus_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    bus_master_if.master bif,
    output logic         busy,
    output logic [15:0]  txn_count
);

    // The latency counter is 4 bits wide, so only 1..15 can be represented.
    if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_rd_latency
        $error("bus_master: RD_LATENCY must be within 1..15");
    end

    state_e            state_q, state_d;
    logic [3:0]        lat_q;
    logic              cmd_valid_q;
    logic              cmd_op_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic              rsp_op_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [15:0]       txn_q;

    // One-cycle control strobes decoded from the current state.
    logic accept;
    logic leave_cmd;
    logic capture;
    logic rsp_done;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        leave_cmd = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bif.req_valid) begin
                    accept  = 1'b1;
                    state_d = CMD;
                end
            end
            CMD: begin
                leave_cmd = 1'b1;
                state_d   = (cmd_op_q == BUS_OP_WRITE) ? RSP : RD_WAIT;
            end
            RD_WAIT: begin
                // Counter holds 1 during the last wait cycle C+RD_LATENCY.
                if (lat_q == 4'd1) begin
                    capture = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (bif.rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and an asynchronous
    // reset, so an in-flight transaction is dropped without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_op_q    <= 1'b0;
            rsp_rdata_q <= '0;
            txn_q       <= '0;
        end else begin
            if (accept) begin
                cmd_valid_q <= 1'b1;
                cmd_op_q    <= bif.req_op;
                cmd_addr_q  <= bif.req_addr;
                cmd_wdata_q <= bif.req_wdata;
            end

            if (leave_cmd) begin
                cmd_valid_q <= 1'b0;
                cmd_op_q    <= 1'b0;
                cmd_addr_q  <= '0;
                cmd_wdata_q <= '0;
                if (cmd_op_q == BUS_OP_WRITE) begin
                    rsp_op_q    <= BUS_OP_WRITE;
                    rsp_rdata_q <= '0;
                end else begin
                    lat_q <= 4'(RD_LATENCY);
                end
            end

            if (state_q == RD_WAIT) begin
                lat_q <= lat_q - 4'd1;
            end

            if (capture) begin
                rsp_op_q    <= BUS_OP_READ;
                rsp_rdata_q <= bif.bus_rd_data;
            end

            if (rsp_done) begin
                txn_q <= txn_q + 16'd1;
            end
        end
    end

    assign bif.req_ready     = (state_q == IDLE);
    assign bif.rsp_valid     = (state_q == RSP);
    assign bif.rsp_op        = rsp_op_q;
    assign bif.rsp_rdata     = rsp_rdata_q;
    assign bif.bus_cmd_valid = cmd_valid_q;
    assign bif.bus_op        = cmd_op_q;
    assign bif.bus_addr      = cmd_addr_q;
    assign bif.bus_wr_data   = cmd_wdata_q;
    assign busy              = (state_q != IDLE);
    assign txn_count         = txn_q;

endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench for bus_master.
// Two instances: dut (RD_LATENCY=1) against a register-file slave, and dut3
// (RD_LATENCY=3) against a slave whose read data changes every cycle.
module tb_bus_master;

    localparam int L1 = 1;
    localparam int L3 = 3;

    logic        clk;
    logic        rst_n;
    logic        busy1, busy3;
    logic [15:0] txn1, txn3;

    bus_master_if #(.ADDR_W(16), .DATA_W(16)) bif1 ();
    bus_master_if #(.ADDR_W(16), .DATA_W(16)) bif3 ();

    bus_master #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(L1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bif       (bif1),
        .busy      (busy1),
        .txn_count (txn1)
    );

    bus_master #(.ADDR_W(16), .DATA_W(16), .RD_LATENCY(L3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bif       (bif3),
        .busy      (busy3),
        .txn_count (txn3)
    );

    always #5 clk = ~clk;

    // Register-file slave for dut: registered read data, cleared by reset.
    logic [15:0] smem [256];
    logic [15:0] s1_rd_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rd_q <= '0;
            for (int i = 0; i < 256; i++) smem[i] <= '0;
        end else if (bif1.bus_cmd_valid) begin
            if (bif1.bus_op) smem[bif1.bus_addr[7:0]] <= bif1.bus_wr_data;
            else             s1_rd_q <= smem[bif1.bus_addr[7:0]];
        end
    end
    assign bif1.bus_rd_data = s1_rd_q;

    // Free-running slave for dut3: read data is 0xA000 + cycle number.
    logic [15:0] cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= '0;
        else        cyc <= cyc + 16'd1;
    end
    assign bif3.bus_rd_data = 16'hA000 + cyc;

    // Reference model state
    logic [15:0] ref_mem [256];
    logic [15:0] exp_cnt;
    logic [15:0] exp_cnt3;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on dut; called at a negedge with dut idle.
    task automatic do_txn(input logic op, input logic [15:0] addr,
                          input logic [15:0] data, input int hold);
        int          n;
        int          extra_cmd;
        logic [15:0] exp_rd;
        chk("req_ready_idle", bif1.req_ready, 1'b1);
        bif1.req_valid = 1'b1;
        bif1.req_op    = op;
        bif1.req_addr  = addr;
        bif1.req_wdata = data;
        bif1.rsp_ready = 1'b0;
        @(negedge clk);
        // Cycle C: scramble request fields; they must not matter any more.
        bif1.req_valid = 1'b0;
        bif1.req_op    = ~op;
        bif1.req_addr  = 16'($urandom);
        bif1.req_wdata = 16'($urandom);
        chk("cmd_valid", bif1.bus_cmd_valid, 1'b1);
        chk("bus_op", bif1.bus_op, op);
        chk("bus_addr", bif1.bus_addr, addr);
        if (op) chk("bus_wr_data", bif1.bus_wr_data, data);
        chk("busy_cmd", busy1, 1'b1);
        chk("req_ready_cmd", bif1.req_ready, 1'b0);
        exp_rd = op ? 16'h0000 : ref_mem[addr[7:0]];
        if (op) ref_mem[addr[7:0]] = data;
        n = 0;
        extra_cmd = 0;
        do begin
            @(negedge clk);
            n++;
            if (bif1.bus_cmd_valid) extra_cmd++;
        end while (!bif1.rsp_valid && n < 20);
        chk("cmd_one_cycle", extra_cmd, 0);
        chk("rsp_latency", n, op ? 1 : 1 + L1);
        chk("rsp_op", bif1.rsp_op, op);
        chk("rsp_rdata", bif1.rsp_rdata, exp_rd);
        chk("bus_addr_clr", bif1.bus_addr, 16'h0000);
        chk("bus_wr_data_clr", bif1.bus_wr_data, 16'h0000);
        for (int i = 0; i < hold; i++) begin
            bif1.req_valid = 1'b1;
            @(negedge clk);
            chk("hold_rsp_valid", bif1.rsp_valid, 1'b1);
            chk("hold_rsp_op", bif1.rsp_op, op);
            chk("hold_rsp_rdata", bif1.rsp_rdata, exp_rd);
            chk("hold_req_ready", bif1.req_ready, 1'b0);
            chk("hold_no_cmd", bif1.bus_cmd_valid, 1'b0);
        end
        bif1.req_valid = 1'b0;
        bif1.rsp_ready = 1'b1;
        @(negedge clk);
        bif1.rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("txn_count", txn1, exp_cnt);
        chk("rsp_valid_done", bif1.rsp_valid, 1'b0);
        chk("busy_done", busy1, 1'b0);
    endtask

    // Start a read on dut, then pulse reset 'after' cycles past the accept.
    task automatic reset_mid(input int after);
        int seen_rsp;
        bif1.req_valid = 1'b1;
        bif1.req_op    = 1'b0;
        bif1.req_addr  = 16'h0009;
        bif1.rsp_ready = 1'b0;
        @(negedge clk);
        bif1.req_valid = 1'b0;
        repeat (after) @(negedge clk);
        chk("pre_reset_cmd", bif1.bus_cmd_valid, (after == 0) ? 1'b1 : 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cmd_valid", bif1.bus_cmd_valid, 1'b0);
        chk("rst_rsp_valid", bif1.rsp_valid, 1'b0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_txn_count", txn1, 16'h0000);
        #1 rst_n = 1'b1;
        exp_cnt = 16'h0000;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        @(negedge clk);
        chk("rst_req_ready", bif1.req_ready, 1'b1);
        seen_rsp = 0;
        repeat (5) begin
            @(negedge clk);
            if (bif1.rsp_valid) seen_rsp++;
        end
        chk("rst_no_rsp", seen_rsp, 0);
        chk("rst_txn_after", txn1, exp_cnt);
    endtask

    initial begin
        int          n;
        int          done;
        int          budget;
        logic [15:0] exp3;

        clk = 1'b0;
        rst_n = 1'b0;
        exp_cnt = '0;
        exp_cnt3 = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        bif1.req_valid = 1'b0; bif1.req_op = 1'b0; bif1.req_addr = '0;
        bif1.req_wdata = '0;   bif1.rsp_ready = 1'b0;
        bif3.req_valid = 1'b0; bif3.req_op = 1'b0; bif3.req_addr = '0;
        bif3.req_wdata = '0;   bif3.rsp_ready = 1'b0;

        // Values while reset is held
        #3;
        chk("in_reset_cmd_valid", bif1.bus_cmd_valid, 1'b0);
        chk("in_reset_rsp_valid", bif1.rsp_valid, 1'b0);
        chk("in_reset_txn", txn1, 16'h0000);
        #19 rst_n = 1'b1;

        // Idle for 10 cycles after reset
        repeat (10) @(negedge clk);
        chk("idle_req_ready", bif1.req_ready, 1'b1);
        chk("idle_busy", busy1, 1'b0);
        chk("idle_cmd_valid", bif1.bus_cmd_valid, 1'b0);
        chk("idle_bus_op", bif1.bus_op, 1'b0);
        chk("idle_bus_addr", bif1.bus_addr, 16'h0000);
        chk("idle_bus_wr_data", bif1.bus_wr_data, 16'h0000);
        chk("idle_rsp_valid", bif1.rsp_valid, 1'b0);
        chk("idle_rsp_op", bif1.rsp_op, 1'b0);
        chk("idle_rsp_rdata", bif1.rsp_rdata, 16'h0000);
        chk("idle_txn", txn1, 16'h0000);

        // Directed: write then two reads, then a held read response
        do_txn(1'b1, 16'h0009, 16'h0001, 0);
        do_txn(1'b0, 16'h0009, 16'h0000, 0);
        do_txn(1'b0, 16'h0005, 16'h0000, 0);
        chk("txn_after_three", txn1, 16'd3);
        do_txn(1'b0, 16'h0009, 16'h0000, 5);

        // RD_LATENCY=3 instance against the per-cycle changing slave
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            bif3.req_valid = 1'b1;
            bif3.req_op    = 1'b0;
            bif3.req_addr  = 16'($urandom);
            @(negedge clk);
            bif3.req_valid = 1'b0;
            chk("l3_cmd_valid", bif3.bus_cmd_valid, 1'b1);
            exp3 = 16'hA000 + cyc + 16'(L3);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bif3.rsp_valid && n < 20);
            chk("l3_latency", n, L3 + 1);
            chk("l3_rsp_op", bif3.rsp_op, 1'b0);
            chk("l3_rsp_rdata", bif3.rsp_rdata, exp3);
            bif3.rsp_ready = 1'b1;
            @(negedge clk);
            bif3.rsp_ready = 1'b0;
            exp_cnt3 = exp_cnt3 + 16'd1;
            chk("l3_txn_count", txn3, exp_cnt3);
            chk("l3_busy_done", busy3, 1'b0);
        end

        // Randomized reads/writes over a small address window
        for (int k = 0; k < 40; k++) begin
            do_txn(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                   16'($urandom), $urandom_range(0, 3));
        end

        // Reset in CMD, then in RD_WAIT
        reset_mid(0);
        reset_mid(1);

        // Counter wrap: 65535 back-to-back writes reach 0xFFFF
        bif1.req_valid = 1'b1;
        bif1.req_op    = 1'b1;
        bif1.req_addr  = 16'h00FF;
        bif1.req_wdata = 16'h5A5A;
        bif1.rsp_ready = 1'b1;
        ref_mem[8'hFF] = 16'h5A5A;
        done = 0;
        budget = 0;
        while (done < 65535 && budget < 65535 * 3 + 100) begin
            @(negedge clk);
            budget++;
            if (bif1.rsp_valid) begin
                done++;
                if (done == 65535) bif1.req_valid = 1'b0;
            end
        end
        chk("wrap_completed", done, 65535);
        @(negedge clk);
        bif1.rsp_ready = 1'b0;
        bif1.req_valid = 1'b0;
        exp_cnt = 16'hFFFF;
        chk("txn_at_max", txn1, exp_cnt);
        do_txn(1'b1, 16'h0003, 16'h1234, 0);
        chk("txn_wrapped", txn1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
